// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that funnels n_req write requesters into a single FIFO
// write port, granting bursts of up to max_burst writes per requester.
module fifo_wr_arbiter #(
    parameter int n_req     = 4,
    parameter int dw        = 8,
    parameter int max_burst = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [n_req-1:0]           req,
    input  logic [n_req*dw-1:0]        data,
    output logic [n_req-1:0]           ack,
    output logic                       fifo_write,
    output logic [dw-1:0]              fifo_data_in,
    input  logic                       fifo_full,
    output logic                       grant_vld,
    output logic [$clog2(n_req)-1:0]   grant_id,
    output logic [15:0]                wr_count,
    output logic [15:0]                stall_count,
    output logic                       o_dbg_state,
    output logic [$clog2(n_req)-1:0]   o_dbg_ptr
);

    localparam int GW = $clog2(n_req);
    localparam logic [3:0] LAST = 4'(max_burst - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        r_state;
    logic [GW-1:0] r_grant_id;
    logic [GW-1:0] r_ptr;
    logic [3:0]    r_burst;
    logic [15:0]   r_wr_count;
    logic [15:0]   r_stall_count;

    logic          w_busy;
    logic          w_req_g;
    logic          w_stall;
    logic          w_any;
    logic [GW-1:0] w_sel;
    logic [GW-1:0] w_ptr_nxt;
    int            w_idx;

    // Outputs are gated by reset so a reset asserted mid-burst writes nothing.
    always_comb begin
        w_busy       = (r_state == BUSY) && !rstn;
        w_req_g      = req[r_grant_id];
        fifo_write   = w_busy && w_req_g && !fifo_full;
        w_stall      = w_busy && w_req_g && fifo_full;
        ack          = '0;
        ack[r_grant_id] = fifo_write;
        fifo_data_in = w_busy ? data[r_grant_id*dw +: dw] : '0;
        w_ptr_nxt    = (int'(r_grant_id) == n_req - 1) ? '0 : r_grant_id + 1'b1;
    end

    // Search from r_ptr upward; iterating downward lets the nearest hit win.
    always_comb begin
        w_any = |req;
        w_sel = '0;
        w_idx = 0;
        for (int i = n_req - 1; i >= 0; i--) begin
            w_idx = (int'(r_ptr) + i) % n_req;
            if (req[w_idx]) w_sel = GW'(w_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state       <= IDLE;
            r_grant_id    <= '0;
            r_ptr         <= '0;
            r_burst       <= '0;
            r_wr_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (fifo_write) r_wr_count <= r_wr_count + 16'd1;
            if (w_stall && r_stall_count != 16'hFFFF)
                r_stall_count <= r_stall_count + 16'd1;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state    <= BUSY;
                        r_grant_id <= w_sel;
                        r_burst    <= '0;
                    end
                end
                BUSY: begin
                    if (!w_req_g || (fifo_write && r_burst == LAST)) begin
                        r_state <= IDLE;
                        r_ptr   <= w_ptr_nxt;
                    end else if (fifo_write) begin
                        r_burst <= r_burst + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant_vld   = w_busy;
    assign grant_id    = r_grant_id;
    assign wr_count    = r_wr_count;
    assign stall_count = r_stall_count;
    assign o_dbg_state = (r_state == BUSY);
    assign o_dbg_ptr   = r_ptr;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter n_req, default 4, meaning number of write requesters (2..8).
REQ-002 SHALL have parameter dw, default 8, meaning data width, equal to the FIFO fifo_width.
REQ-003 SHALL have parameter max_burst, default 4, meaning max consecutive writes per grant (1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-006 SHALL have port req  input  n_req  per-requester write request, bit i for requester i.
REQ-007 SHALL have port data  input  n_req*dw  per-requester write data, slice i = bits [i*dw +: dw].
REQ-008 SHALL have port ack  output  n_req  per-requester write accepted, one-hot or zero.
REQ-009 SHALL have port fifo_write  output  1  write strobe to FIFO.
REQ-010 SHALL have port fifo_data_in  output  dw  write data to FIFO.
REQ-011 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-012 SHALL have port grant_vld  output  1  a requester currently holds the grant.
REQ-013 SHALL have port grant_id  output  $clog2(n_req)  index of the granted requester.
REQ-014 SHALL have port wr_count  output  16  total accepted writes, wraps at 2^16.
REQ-015 SHALL have port stall_count  output  16  cycles granted-but-blocked by full, saturates at 16'hFFFF.

Function
REQ-016 SHALL implement a two-state FSM: IDLE, BUSY; registered state, grant_id, burst count (4 bit), round-robin pointer ptr.
REQ-017 SHALL, in IDLE with any req bit set, select the first set bit searching ptr, ptr+1, ... modulo n_req, load grant_id, clear burst count, enter BUSY next cycle.
REQ-018 SHALL issue no write in IDLE; arbitration latency from req rise to first possible write is 1 cycle.
REQ-019 SHALL in BUSY drive fifo_write = req[grant_id] & !fifo_full, combinationally.
REQ-020 SHALL drive ack[grant_id] = fifo_write and all other ack bits 0.
REQ-021 SHALL drive fifo_data_in = data slice grant_id in BUSY, and all-zero in IDLE.
REQ-022 SHALL increment burst count and wr_count on each cycle with fifo_write=1.
REQ-023 SHALL increment stall_count (saturating) on each BUSY cycle with req[grant_id]=1 and fifo_full=1; stalled cycles do not advance burst count.
REQ-024 SHALL release the grant (BUSY->IDLE, ptr <= grant_id+1 mod n_req) when a write occurs with burst count = max_burst-1.
REQ-025 SHALL release the grant the same way in any BUSY cycle where req[grant_id]=0; that cycle issues no write.
REQ-026 SHALL hold the grant indefinitely while req[grant_id]=1 and fifo_full=1 (no preemption on full).
REQ-027 SHALL ignore req changes of non-granted requesters while in BUSY.
REQ-028 SHALL drive grant_vld=1 exactly when state is BUSY; grant_id is valid only then.
REQ-029 SHALL never assert fifo_write while fifo_full=1.

Reset
REQ-030 SHALL on rstn=1 at a clock edge force state IDLE, ptr 0, grant_id 0, burst count 0, wr_count 0, stall_count 0.
REQ-031 SHALL hold ack=0, fifo_write=0, fifo_data_in=0, grant_vld=0 during and in the cycle after reset, regardless of req.
REQ-032 SHALL abort any in-progress burst on reset mid-BUSY; no write in the reset cycle.

Verification
REQ-033 SHALL cover: req=4'b0001, data0=8'hA5, fifo_full=0 -> grant_vld 1 cycle later, grant_id 0, 4 writes of A5, release, wr_count=4.
REQ-034 SHALL cover: req=4'b1111 held, full=0, max_burst=4 -> bursts of 4 in order 0,1,2,3,0, one idle arbitration cycle between bursts.
REQ-035 SHALL cover: granted req 2 with fifo_full=1 for 5 cycles -> fifo_write=0, ack=0, grant held, stall_count=5, burst count unchanged.
REQ-036 SHALL cover: req1 drops after 2 writes -> grant released, ptr=2, wr_count=2, next grant to requester 2 if requesting.
REQ-037 SHALL cover: rstn=1 mid-burst (requester 3, 2 writes done) -> next cycle IDLE, counters 0, ptr 0, first grant to lowest set req.
REQ-038 SHALL cover: max_burst=1, req=4'b0101 -> alternating single writes 0,2,0,2; wr_count increments by 1 per 2 cycles.
